// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial word serializer.
package word_serializer_pkg;

   // Control states: waiting for a word, sending data beats, sending the parity beat
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   // Beat counter width: enough to hold 0..N
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Even parity (XOR reduction) over a zero-extended word
   function automatic logic word_parity(input logic [63:0] w);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 64; i++) begin
         p = p ^ w[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/word_serializer.sv
// Serializes an N-bit parallel word into single-bit beats with an optional
// trailing even-parity beat. Valid/ready on both sides; back-to-back words
// are accepted on the final beat with no idle bubble.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          LSB_FIRST = 1'b1,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         ser_out,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         ser_last,
   output logic         busy
);

   localparam int unsigned CW = cnt_width(N);

   state_t         state_q;
   state_t         state_d;
   logic [N-1:0]   shreg_q;
   logic [CW-1:0]  cnt_q;
   logic           par_q;

   logic           accept_c;
   logic           xfer_c;
   logic           cnt_last_c;

   // Handshake qualifiers shared by the FSM and the datapath
   assign cnt_last_c = (cnt_q == CW'(N - 1));
   assign accept_c   = in_valid && in_ready;
   assign xfer_c     = ser_valid && ser_ready;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a final-beat transfer may chain straight into a new word
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (xfer_c && cnt_last_c) begin
               if (PARITY_EN) begin
                  state_d = PAR;
               end else if (accept_c) begin
                  state_d = SHIFT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         PAR: begin
            if (xfer_c) begin
               state_d = accept_c ? SHIFT : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the registered state and datapath
   always_comb begin
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      ser_last  = 1'b0;
      busy      = 1'b0;
      case (state_q)
         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = shreg_q[0];
            ser_last  = !PARITY_EN && cnt_last_c;
            busy      = 1'b1;
         end
         PAR: begin
            ser_valid = 1'b1;
            ser_out   = par_q;
            ser_last  = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            ser_valid = 1'b0;
         end
      endcase
      in_ready = (state_q == IDLE) || (ser_valid && ser_ready && ser_last);
   end

   // Datapath: load reordered word and parity on accept, shift on each data beat
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else if (accept_c) begin
         for (int i = 0; i < int'(N); i++) begin
            shreg_q[i] <= LSB_FIRST ? in_data[i] : in_data[int'(N) - 1 - i];
         end
         par_q <= word_parity(64'(in_data));
         cnt_q <= '0;
      end else if ((state_q == SHIFT) && xfer_c) begin
         shreg_q <= shreg_q >> 1;
         if (!cnt_last_c) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: three configurations, directed words,
// expected beats queued at stimulus time and checked by per-instance monitors.
module tb_word_serializer;

   typedef struct packed {
      logic b;
      logic last;
   } beat_t;

   logic clock = 1'b0;
   logic reset;

   // Instance A: N=8, LSB first, parity
   logic [7:0] a_in_data;
   logic       a_in_valid, a_in_ready, a_ser_out, a_ser_valid, a_ser_ready, a_ser_last, a_busy;
   // Instance B: N=8, MSB first, parity
   logic [7:0] b_in_data;
   logic       b_in_valid, b_in_ready, b_ser_out, b_ser_valid, b_ser_ready, b_ser_last, b_busy;
   // Instance C: N=1, no parity
   logic       c_in_data;
   logic       c_in_valid, c_in_ready, c_ser_out, c_ser_valid, c_ser_ready, c_ser_last, c_busy;

   beat_t qa[$];
   beat_t qb[$];
   beat_t qc[$];

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   word_serializer #(.N(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
      .clock(clock), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
      .ser_ready(a_ser_ready), .ser_last(a_ser_last), .busy(a_busy));

   word_serializer #(.N(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_b (
      .clock(clock), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
      .ser_ready(b_ser_ready), .ser_last(b_ser_last), .busy(b_busy));

   word_serializer #(.N(1), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) dut_c (
      .clock(clock), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .ser_out(c_ser_out), .ser_valid(c_ser_valid),
      .ser_ready(c_ser_ready), .ser_last(c_ser_last), .busy(c_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input int w, input logic v, input logic l);
      beat_t e;
      e.b    = v;
      e.last = l;
      case (w)
         0:       qa.push_back(e);
         1:       qb.push_back(e);
         default: qc.push_back(e);
      endcase
   endtask

   // bits[0] is the first beat on the wire; only the final beat is last
   task automatic push_seq(input int w, input logic [17:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         push_beat(w, bits[i], (i == n - 1));
      end
   endtask

   function automatic logic get_ready(input int w);
      case (w)
         0:       return a_in_ready;
         1:       return b_in_ready;
         default: return c_in_ready;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         0:       return a_busy;
         1:       return b_busy;
         default: return c_busy;
      endcase
   endfunction

   function automatic int qsize(input int w);
      case (w)
         0:       return qa.size();
         1:       return qb.size();
         default: return qc.size();
      endcase
   endfunction

   task automatic set_in(input int w, input logic v, input logic [7:0] d);
      case (w)
         0:       begin a_in_valid = v; a_in_data = d; end
         1:       begin b_in_valid = v; b_in_data = d; end
         default: begin c_in_valid = v; c_in_data = d[0]; end
      endcase
   endtask

   // Called at posedge+1; returns at accept edge +1
   task automatic send(input int w, input logic [7:0] d);
      logic r;
      set_in(w, 1'b1, d);
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         r = get_ready(w);
         @(posedge clock);
         #1;
         if (r) begin
            set_in(w, 1'b0, 8'h00);
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL send_timeout: inst=%0d word=%0h never accepted", w, d);
      set_in(w, 1'b0, 8'h00);
   endtask

   task automatic wait_idle(input int w);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (qsize(w) == 0 && !get_busy(w)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: inst=%0d queue=%0d busy=%0b", w, qsize(w), get_busy(w));
      end
      check("queue_drained", 32'(qsize(w)), 32'd0);
      @(posedge clock);
      #1;
   endtask

   // Monitors: pop and compare on every transferred beat
   beat_t ea, eb, ec;
   logic  a_prev_stall = 1'b0;
   logic  a_prev_out   = 1'b0;
   logic  a_prev_last  = 1'b0;

   always @(negedge clock) begin
      if (!reset && a_ser_valid && a_ser_ready) begin
         if (qa.size() == 0) begin
            total++;
            bad++;
            $display("FAIL a_extra_beat: got ser_out=%0b with nothing expected", a_ser_out);
         end else begin
            ea = qa.pop_front();
            check("a_ser_out", 32'(a_ser_out), 32'(ea.b));
            check("a_ser_last", 32'(a_ser_last), 32'(ea.last));
         end
      end
      if (a_prev_stall) begin
         check("a_stall_valid", 32'(a_ser_valid), 32'd1);
         check("a_stall_out", 32'(a_ser_out), 32'(a_prev_out));
         check("a_stall_last", 32'(a_ser_last), 32'(a_prev_last));
      end
      a_prev_stall = !reset && a_ser_valid && !a_ser_ready;
      a_prev_out   = a_ser_out;
      a_prev_last  = a_ser_last;
   end

   always @(negedge clock) begin
      if (!reset && b_ser_valid && b_ser_ready) begin
         if (qb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_extra_beat: got ser_out=%0b with nothing expected", b_ser_out);
         end else begin
            eb = qb.pop_front();
            check("b_ser_out", 32'(b_ser_out), 32'(eb.b));
            check("b_ser_last", 32'(b_ser_last), 32'(eb.last));
         end
      end
   end

   always @(negedge clock) begin
      if (!reset && c_ser_valid && c_ser_ready) begin
         if (qc.size() == 0) begin
            total++;
            bad++;
            $display("FAIL c_extra_beat: got ser_out=%0b with nothing expected", c_ser_out);
         end else begin
            ec = qc.pop_front();
            check("c_ser_out", 32'(c_ser_out), 32'(ec.b));
            check("c_ser_last", 32'(c_ser_last), 32'(ec.last));
         end
      end
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int bcyc, stalls, vcount, vrun, vmax, pulses;

   initial begin
      reset = 1'b1;
      a_in_valid = 1'b0; a_in_data = 8'h00; a_ser_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = 8'h00; b_ser_ready = 1'b1;
      c_in_valid = 1'b0; c_in_data = 1'b0;  c_ser_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // Reset state
      check("rst_ser_valid", 32'(a_ser_valid), 32'd0);
      check("rst_ser_out", 32'(a_ser_out), 32'd0);
      check("rst_ser_last", 32'(a_ser_last), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      reset = 1'b0;
      #1;
      check("rst_in_ready_a", 32'(a_in_ready), 32'd1);
      check("rst_in_ready_c", 32'(c_in_ready), 32'd1);
      @(posedge clock);
      #1;

      // A5 LSB first: 1,0,1,0,0,1,0,1 then parity 0
      push_seq(0, 18'h000A5, 9);
      send(0, 8'hA5);
      check("a5_first_beat_valid", 32'(a_ser_valid), 32'd1);
      check("a5_first_beat_out", 32'(a_ser_out), 32'd1);
      wait_idle(0);

      // C1 MSB first: 1,1,0,0,0,0,0,1 then parity 1
      push_seq(1, 18'h00183, 9);
      send(1, 8'hC1);
      wait_idle(1);

      // Backpressure 1,0,0,1,... on A5
      push_seq(0, 18'h000A5, 9);
      bcyc = 0;
      stalls = 0;
      fork
         send(0, 8'hA5);
         begin
            for (int i = 0; i < 40; i++) begin
               @(negedge clock);
               if (a_busy) bcyc++;
               if (a_ser_valid && !a_ser_ready) stalls++;
               @(posedge clock);
               #1;
               a_ser_ready = (((i + 1) % 4) == 0) || (((i + 1) % 4) == 3);
            end
            a_ser_ready = 1'b1;
         end
      join
      wait_idle(0);
      check("bp_stalls_seen", 32'(stalls > 0), 32'd1);
      check("bp_total_cycles", 32'(bcyc), 32'(9 + stalls));

      // Back-to-back 01 then FF with in_valid held
      push_seq(0, 18'h00101, 9);
      push_seq(0, 18'h000FF, 9);
      vcount = 0; vrun = 0; vmax = 0; pulses = 0;
      fork
         begin
            send(0, 8'h01);
            send(0, 8'hFF);
         end
         begin
            repeat (30) begin
               @(negedge clock);
               if (a_ser_valid) begin
                  vcount++;
                  vrun++;
                  if (vrun > vmax) vmax = vrun;
               end else begin
                  vrun = 0;
               end
               if (a_in_valid && a_in_ready && a_busy) pulses++;
            end
         end
      join
      wait_idle(0);
      check("b2b_valid_beats", 32'(vcount), 32'd18);
      check("b2b_consecutive", 32'(vmax), 32'd18);
      check("b2b_ready_pulse", 32'(pulses), 32'd1);

      // Reset during beat 4 of 3C: only beats 0,0,1 complete
      push_beat(0, 1'b0, 1'b0);
      push_beat(0, 1'b0, 1'b0);
      push_beat(0, 1'b1, 1'b0);
      send(0, 8'h3C);
      repeat (3) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_ser_valid", 32'(a_ser_valid), 32'd0);
      check("mid_rst_ser_out", 32'(a_ser_out), 32'd0);
      check("mid_rst_ser_last", 32'(a_ser_last), 32'd0);
      check("mid_rst_busy", 32'(a_busy), 32'd0);
      check("mid_rst_beats_seen", 32'(qa.size()), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("post_rst_valid", 32'(a_ser_valid), 32'd0);
      end
      check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
      @(posedge clock);
      #1;

      // N=1, no parity: 1,0,1 each a last beat
      push_beat(2, 1'b1, 1'b1);
      push_beat(2, 1'b0, 1'b1);
      push_beat(2, 1'b1, 1'b1);
      send(2, 8'h01);
      send(2, 8'h00);
      send(2, 8'h01);
      wait_idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
